// File: rtl/tod_pkg.sv
// Shared constants, state encoding and helpers for the time-of-day transmitter.
package tod_pkg;

  localparam int TIMESTAMP_WIDTH_DEFAULT = 64;
  localparam int SECONDS_WIDTH           = TIMESTAMP_WIDTH_DEFAULT / 2;

  localparam logic [7:0] EVCODE_SHIFT_ZERO_DEFAULT     = 8'h70;
  localparam logic [7:0] EVCODE_SHIFT_ONE_DEFAULT      = 8'h71;
  localparam logic [7:0] EVCODE_SECONDS_MARKER_DEFAULT = 8'h7D;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MARKER   = 3'd1,
    ST_DELAY    = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_SPACE    = 3'd4,
    ST_WAIT_PPS = 3'd5
  } tod_state_e;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tod_pps_freewheel.sv
// PPS supervision: produces an internal one-cycle PPS strobe when the external
// PPS goes missing. Only instantiated when TOD_TX_PPS_FREEWHEEL_EN is defined.
module tod_pps_freewheel #(
  parameter int unsigned NOMINAL_CLK_RATE = 125000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pps_ext,
  output logic pps_int,
  output logic freewheel_active
);

  localparam int unsigned FIRST_LIMIT = NOMINAL_CLK_RATE + NOMINAL_CLK_RATE / 100;
  localparam int          CNT_W       = $clog2(FIRST_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIM_FIRST = CNT_W'(FIRST_LIMIT);
  localparam logic [CNT_W-1:0] LIM_NOM   = CNT_W'(NOMINAL_CLK_RATE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;
  logic             active_q, active_d;
  logic [CNT_W-1:0] limit;

  // cnt_q holds the number of clocks elapsed since the last (external or
  // internal) PPS; supervision is armed only after the first external PPS.
  always_comb begin
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    active_d = active_q;
    pps_int  = 1'b0;
    limit    = active_q ? LIM_NOM : LIM_FIRST;
    if (pps_ext) begin
      cnt_d    = CNT_W'(1);
      armed_d  = 1'b1;
      active_d = 1'b0;
    end else if (armed_q) begin
      if (cnt_q == limit) begin
        pps_int  = 1'b1;
        cnt_d    = CNT_W'(1);
        active_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      active_q <= active_d;
    end
  end

  assign freewheel_active = active_q;

endmodule

// File: rtl/tod_transmitter.sv
// Time-of-day event generator: seconds marker on PPS, then the next seconds
// value MSB-first as shift codes. Optional PPS freewheel: TOD_TX_PPS_FREEWHEEL_EN.
module tod_transmitter
  import tod_pkg::*;
#(
  parameter int unsigned NOMINAL_CLK_RATE      = 125000000,
  parameter int          TIMESTAMP_WIDTH       = TIMESTAMP_WIDTH_DEFAULT,
  parameter logic [7:0]  EVCODE_SHIFT_ZERO     = EVCODE_SHIFT_ZERO_DEFAULT,
  parameter logic [7:0]  EVCODE_SHIFT_ONE      = EVCODE_SHIFT_ONE_DEFAULT,
  parameter logic [7:0]  EVCODE_SECONDS_MARKER = EVCODE_SECONDS_MARKER_DEFAULT,
  parameter int unsigned SHIFT_DELAY_CLOCKS    = 1000,
  parameter int unsigned BIT_SPACING_CLOCKS    = 4,
  parameter int          STATUS_COUNTER_WIDTH  = 10,
  localparam int         SEC_W                 = TIMESTAMP_WIDTH / 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ppsIn,
  input  logic [SEC_W-1:0]                secondsIn,
  input  logic                            secondsLoad,
  output logic [7:0]                      evCode,
  output logic                            evCodeValid,
  input  logic                            evCodeReady,
  output logic [SEC_W-1:0]                seconds,
  output logic                            secondsValid,
  output logic                            freewheelActive,
  output logic [STATUS_COUNTER_WIDTH-1:0] shiftAbortCounter,
  output logic [STATUS_COUNTER_WIDTH-1:0] ppsMissedCounter,
  output tod_state_e                      dbg_state
);

  localparam int          BIT_W   = (SEC_W > 1) ? $clog2(SEC_W) : 1;
  localparam int unsigned CNT_MAX = max2(SHIFT_DELAY_CLOCKS, BIT_SPACING_CLOCKS);
  localparam int          CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(SHIFT_DELAY_CLOCKS - 1);
  localparam logic [CNT_W-1:0] SPACE_LOAD = CNT_W'(BIT_SPACING_CLOCKS - 1);
  localparam logic [BIT_W-1:0] MSB_IDX    = BIT_W'(SEC_W - 1);

  tod_state_e                      state_q, state_d;
  logic [SEC_W-1:0]                tx_seconds_q, tx_seconds_d;
  logic [SEC_W-1:0]                load_val_q, load_val_d;
  logic [SEC_W-1:0]                seconds_q, seconds_d;
  logic                            load_pending_q, load_pending_d;
  logic                            loaded_q, loaded_d;
  logic                            seconds_valid_q, seconds_valid_d;
  logic [BIT_W-1:0]                bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [STATUS_COUNTER_WIDTH-1:0] abort_cnt_q, abort_cnt_d;
  logic [STATUS_COUNTER_WIDTH-1:0] missed_cnt_q, missed_cnt_d;

  logic       pps;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       accept;

`ifdef TOD_TX_PPS_FREEWHEEL_EN
  logic pps_int;
  logic fw_active;

  tod_pps_freewheel #(
    .NOMINAL_CLK_RATE(NOMINAL_CLK_RATE)
  ) u_pps_freewheel (
    .clk             (clk),
    .rst             (rst),
    .pps_ext         (ppsIn),
    .pps_int         (pps_int),
    .freewheel_active(fw_active)
  );

  assign pps             = ppsIn | pps_int;
  assign freewheelActive = fw_active;
`else
  assign pps             = ppsIn;
  assign freewheelActive = 1'b0;
`endif

  // Handshake: evCode transfers on a cycle where evCodeValid && evCodeReady.
  // Valid/code come straight from the state register, so a presented code is
  // held until accepted; only a PPS (marker preemption) or reset withdraws it.
  always_comb begin
    state_d         = state_q;
    tx_seconds_d    = tx_seconds_q;
    load_val_d      = load_val_q;
    seconds_d       = seconds_q;
    load_pending_d  = load_pending_q;
    loaded_d        = loaded_q;
    seconds_valid_d = seconds_valid_q;
    bit_idx_d       = bit_idx_q;
    cnt_d           = cnt_q;
    abort_cnt_d     = abort_cnt_q;
    missed_cnt_d    = missed_cnt_q;
    ev_valid        = 1'b0;
    ev_code         = '0;

    case (state_q)
      ST_MARKER: begin
        ev_valid = 1'b1;
        ev_code  = EVCODE_SECONDS_MARKER;
      end
      ST_SHIFT: begin
        ev_valid = 1'b1;
        ev_code  = tx_seconds_q[bit_idx_q] ? EVCODE_SHIFT_ONE : EVCODE_SHIFT_ZERO;
      end
      default: ;
    endcase
    accept = ev_valid && evCodeReady;

    case (state_q)
      ST_MARKER: begin
        if (accept) begin
          seconds_d       = tx_seconds_q;
          seconds_valid_d = loaded_q;
          if (load_pending_q) begin
            tx_seconds_d   = load_val_q;
            loaded_d       = 1'b1;
            load_pending_d = 1'b0;
          end else begin
            tx_seconds_d = tx_seconds_q + 1'b1;
          end
          if (load_pending_q || loaded_q) begin
            if (SHIFT_DELAY_CLOCKS == 0) begin
              state_d   = ST_SHIFT;
              bit_idx_d = MSB_IDX;
            end else begin
              state_d = ST_DELAY;
              cnt_d   = DELAY_LOAD;
            end
          end else begin
            state_d = ST_WAIT_PPS;
          end
        end
      end
      ST_DELAY: begin
        if (cnt_q == '0) begin
          state_d   = ST_SHIFT;
          bit_idx_d = MSB_IDX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          if (bit_idx_q == '0) begin
            state_d = ST_WAIT_PPS;
          end else begin
            bit_idx_d = bit_idx_q - 1'b1;
            if (BIT_SPACING_CLOCKS == 0) begin
              state_d = ST_SHIFT;
            end else begin
              state_d = ST_SPACE;
              cnt_d   = SPACE_LOAD;
            end
          end
        end
      end
      ST_SPACE: begin
        if (cnt_q == '0) begin
          state_d = ST_SHIFT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase

    // A load in the same cycle as marker acceptance wins over the clear above,
    // so that value is applied at the following marker.
    if (secondsLoad) begin
      load_val_d     = secondsIn;
      load_pending_d = 1'b1;
    end

    if (pps) begin
      state_d = ST_MARKER;
      if ((state_q == ST_DELAY || state_q == ST_SHIFT || state_q == ST_SPACE) &&
          (abort_cnt_q != '1)) begin
        abort_cnt_d = abort_cnt_q + 1'b1;
      end
      if (state_q == ST_MARKER && !accept && (missed_cnt_q != '1)) begin
        missed_cnt_d = missed_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      tx_seconds_q    <= '0;
      load_val_q      <= '0;
      seconds_q       <= '0;
      load_pending_q  <= 1'b0;
      loaded_q        <= 1'b0;
      seconds_valid_q <= 1'b0;
      bit_idx_q       <= '0;
      cnt_q           <= '0;
      abort_cnt_q     <= '0;
      missed_cnt_q    <= '0;
    end else begin
      state_q         <= state_d;
      tx_seconds_q    <= tx_seconds_d;
      load_val_q      <= load_val_d;
      seconds_q       <= seconds_d;
      load_pending_q  <= load_pending_d;
      loaded_q        <= loaded_d;
      seconds_valid_q <= seconds_valid_d;
      bit_idx_q       <= bit_idx_d;
      cnt_q           <= cnt_d;
      abort_cnt_q     <= abort_cnt_d;
      missed_cnt_q    <= missed_cnt_d;
    end
  end

  assign evCode            = ev_code;
  assign evCodeValid       = ev_valid;
  assign seconds           = seconds_q;
  assign secondsValid      = seconds_valid_q;
  assign shiftAbortCounter = abort_cnt_q;
  assign ppsMissedCounter  = missed_cnt_q;
  assign dbg_state         = state_q;

endmodule
